// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Contents:
//   op_t    - operation codes seen on the op port (MUL, MULH, DIV, REM)
//   state_t - control states of the sequencer (IDLE, PREP, RUN, FIX)
//   twosMag - two's-complement magnitude helper used when forming operand
//             magnitudes; callers size-cast into and out of MAG_W bits.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MULH = 2'b01,
    OP_DIV  = 2'b10,
    OP_REM  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PREP = 2'b01,
    RUN  = 2'b10,
    FIX  = 2'b11
  } state_t;

  // Widest operand the helper handles; the low bits of a negation depend
  // only on the low bits of the input, so zero-extending into this width
  // and truncating the answer is exact for any narrower operand.
  localparam int MAG_W = 64;

  function automatic logic [MAG_W-1:0] twosMag(input logic [MAG_W-1:0] v,
                                               input logic neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the multi-cycle multiply/divide datapath.
// Ports:
//   i_isDiv   - 1 = restoring shift-subtract step, 0 = shift-add step
//   i_acc     - accumulator (partial high product / partial remainder)
//   i_sr      - shift register (multiplier bits / dividend-quotient bits)
//   i_operand - multiplicand magnitude or divisor magnitude
//   o_acc     - accumulator after this iteration
//   o_sr      - shift register after this iteration
module muldiv_step #(
  parameter int WIDTH = 16
) (
  input  logic             i_isDiv,
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_sr,
  input  logic [WIDTH-1:0] i_operand,
  output logic [WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0] o_sr
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shHi;
  logic [WIDTH-1:0] w_diff;
  logic             w_fits;

  // Multiply: {acc,sr} holds the growing product with the unused multiplier
  // bits in the low end; add the multiplicand when the current bit is set,
  // then shift the whole pair right by one.
  // Divide: shift {acc,sr} left by one and subtract the divisor from the
  // top part when it fits; the quotient bit enters at the bottom of sr.
  // The shifted top part needs WIDTH+1 bits for the compare, but since the
  // remainder stays below the divisor the kept value always fits WIDTH bits.
  always_comb begin
    w_sum  = {1'b0, i_acc} + {1'b0, i_operand};
    w_shHi = {i_acc, i_sr[WIDTH-1]};
    w_fits = (w_shHi >= {1'b0, i_operand});
    w_diff = w_shHi[WIDTH-1:0] - i_operand;
    o_acc  = '0;
    o_sr   = '0;
    if (i_isDiv) begin
      o_acc = w_fits ? w_diff : w_shHi[WIDTH-1:0];
      o_sr  = {i_sr[WIDTH-2:0], w_fits};
    end else if (i_sr[0]) begin
      o_acc = w_sum[WIDTH:1];
      o_sr  = {w_sum[0], i_sr[WIDTH-1:1]};
    end else begin
      o_acc = {1'b0, i_acc[WIDTH-1:1]};
      o_sr  = {i_acc[0], i_sr[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/iter_muldiv.sv
// Multi-cycle multiply/divide unit with start/busy/done handshake.
// Every operation takes WIDTH+2 cycles from acceptance to done.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   start     - request, accepted in IDLE or in the done cycle
//   op        - 00 MUL low half, 01 MULH high half, 10 DIV, 11 REM
//   sgn       - two's-complement operands (only when SIGNED_EN=1)
//   a, b      - multiplicand/dividend, multiplier/divisor
//   busy      - operation in progress
//   done      - one-cycle pulse; result and div_zero valid from here on
//   result    - held until the next done
//   div_zero  - DIV/REM with b==0, held with result
module iter_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_nextState;
  logic             w_accept;
  logic             w_lastStep;

  op_t              r_op;
  logic             r_sgn;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_operand;
  logic             r_negRes;
  logic             r_divZero;
  logic             r_ovf;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_result;
  logic             r_divZeroOut;

  logic             w_isDiv;
  logic             w_aNeg;
  logic             w_bNeg;
  logic [WIDTH-1:0] w_magA;
  logic [WIDTH-1:0] w_magB;
  logic [WIDTH-1:0] w_stepAcc;
  logic [WIDTH-1:0] w_stepSr;
  logic [2*WIDTH-1:0] w_prodMag;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_fixed;

  assign w_isDiv  = (r_op == OP_DIV) || (r_op == OP_REM);
  assign w_aNeg   = r_sgn & r_a[WIDTH-1];
  assign w_bNeg   = r_sgn & r_b[WIDTH-1];
  assign w_magA   = WIDTH'(twosMag(MAG_W'(r_a), w_aNeg));
  assign w_magB   = WIDTH'(twosMag(MAG_W'(r_b), w_bNeg));
  assign result   = r_result;
  assign div_zero = r_divZeroOut;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_isDiv   (w_isDiv),
    .i_acc     (r_acc),
    .i_sr      (r_sr),
    .i_operand (r_operand),
    .o_acc     (w_stepAcc),
    .o_sr      (w_stepSr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // FIX is the done cycle: the last RUN step and the sign correction are
  // registered together on the edge leaving RUN, so the result is already
  // valid while done is high. FIX accepts a new start just like IDLE, which
  // gives back-to-back operation without a dead cycle.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_lastStep  = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_nextState = PREP;
        end
      end
      PREP: begin
        busy        = 1'b1;
        w_nextState = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (r_count == CW'(WIDTH - 1)) begin
          w_lastStep  = 1'b1;
          w_nextState = FIX;
        end
      end
      FIX: begin
        done = 1'b1;
        if (start) begin
          w_accept    = 1'b1;
          w_nextState = PREP;
        end else begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Sign correction and special cases, fed straight from the final
  // iteration. The product sign is applied to the full double-width
  // magnitude so MULH sees the correct high half. Divide-by-zero and the
  // most-negative / -1 overflow bypass the iterative answer.
  always_comb begin
    w_prodMag = {w_stepAcc, w_stepSr};
    w_prod    = r_negRes ? -w_prodMag : w_prodMag;
    w_quot    = r_negRes ? -w_stepSr : w_stepSr;
    w_rem     = r_negRes ? -w_stepAcc : w_stepAcc;
    w_fixed   = '0;
    case (r_op)
      OP_MUL:  w_fixed = w_prod[WIDTH-1:0];
      OP_MULH: w_fixed = w_prod[2*WIDTH-1:WIDTH];
      OP_DIV: begin
        if (r_divZero)  w_fixed = '1;
        else if (r_ovf) w_fixed = r_a;
        else            w_fixed = w_quot;
      end
      OP_REM: begin
        if (r_divZero)  w_fixed = r_a;
        else if (r_ovf) w_fixed = '0;
        else            w_fixed = w_rem;
      end
      default: w_fixed = '0;
    endcase
  end

  // Operand capture, preparation, iteration and result registers.
  // The remainder takes the dividend's sign; product and quotient take the
  // xor of both operand signs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op         <= OP_MUL;
      r_sgn        <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_acc        <= '0;
      r_sr         <= '0;
      r_operand    <= '0;
      r_negRes     <= 1'b0;
      r_divZero    <= 1'b0;
      r_ovf        <= 1'b0;
      r_count      <= '0;
      r_result     <= '0;
      r_divZeroOut <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op  <= op_t'(op);
        r_sgn <= sgn & SIGNED_EN;
        r_a   <= a;
        r_b   <= b;
      end
      case (r_state)
        PREP: begin
          r_acc     <= '0;
          r_sr      <= w_magA;
          r_operand <= w_magB;
          r_negRes  <= (r_op == OP_REM) ? w_aNeg : (w_aNeg ^ w_bNeg);
          r_divZero <= (r_b == '0);
          r_ovf     <= r_sgn & (r_a == {1'b1, {(WIDTH-1){1'b0}}}) & (r_b == '1);
          r_count   <= '0;
        end
        RUN: begin
          r_acc   <= w_stepAcc;
          r_sr    <= w_stepSr;
          r_count <= w_lastStep ? '0 : r_count + CW'(1);
        end
        default: ;
      endcase
      if (w_lastStep) begin
        r_result     <= w_fixed;
        r_divZeroOut <= w_isDiv & r_divZero;
      end
    end
  end

endmodule

// File: tb/tb_iter_muldiv.sv
// Self-checking bench for iter_muldiv (WIDTH=16). Two instances share the
// inputs: one with SIGNED_EN=1, one with SIGNED_EN=0, so every operation
// is checked in both configurations against an arithmetic reference model.
module tb_iter_muldiv;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic        sgn;
  logic [15:0] a;
  logic [15:0] b;
  logic        busyS, doneS, dzS;
  logic [15:0] resultS;
  logic        busyU, doneU, dzU;
  logic [15:0] resultU;

  int total;
  int bad;

  iter_muldiv #(.WIDTH(16), .SIGNED_EN(1'b1)) u_dutS (
    .clk(clk), .rst(rst), .start(start), .op(op), .sgn(sgn), .a(a), .b(b),
    .busy(busyS), .done(doneS), .result(resultS), .div_zero(dzS)
  );

  iter_muldiv #(.WIDTH(16), .SIGNED_EN(1'b0)) u_dutU (
    .clk(clk), .rst(rst), .start(start), .op(op), .sgn(sgn), .a(a), .b(b),
    .busy(busyU), .done(doneU), .result(resultU), .div_zero(dzU)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the operand values.
  function automatic logic [15:0] refModel(input logic [1:0] o, input logic s,
                                           input logic [15:0] x, input logic [15:0] y,
                                           output logic dz);
    longint va, vb, p;
    logic [63:0] pb;
    logic [15:0] res;
    va  = s ? longint'($signed(x)) : longint'(x);
    vb  = s ? longint'($signed(y)) : longint'(y);
    dz  = 1'b0;
    res = '0;
    if (o == 2'b00 || o == 2'b01) begin
      p   = va * vb;
      pb  = p;
      res = o[0] ? pb[31:16] : pb[15:0];
    end else if (y == 16'h0000) begin
      dz  = 1'b1;
      res = o[0] ? x : 16'hFFFF;
    end else begin
      p   = o[0] ? (va % vb) : (va / vb);
      pb  = p;
      res = pb[15:0];
    end
    return res;
  endfunction

  // Issues one operation (caller is 1 time unit after a rising edge, DUT
  // idle or in its done cycle), scrambles the inputs while busy, and checks
  // latency, busy, and both results in the done cycle.
  task automatic doOp(input logic [1:0] o, input logic s, input logic [15:0] x,
                      input logic [15:0] y, input string tag);
    logic [15:0] eS, eU;
    logic        dS, dU;
    int          n;
    bit          busyBad;
    eS = refModel(o, s, x, y, dS);
    eU = refModel(o, 1'b0, x, y, dU);
    op = o; sgn = s; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op = 2'($urandom); sgn = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
    n = 1;
    busyBad = 1'b0;
    while (!doneS && n < 40) begin
      if (!busyS || !busyU || doneU) busyBad = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (n !== 18) begin
      bad++; $display("[TB] FAIL %s latency: got %0d cycles, want 18", tag, n);
    end
    total++;
    if (busyBad !== 1'b0) begin
      bad++; $display("[TB] FAIL %s busy: dropped or done early, got 0, want 1", tag);
    end
    total++;
    if ({busyS, busyU, doneU} !== 3'b001) begin
      bad++; $display("[TB] FAIL %s done-cycle flags: busyS/busyU/doneU=%b, want 001", tag,
                      {busyS, busyU, doneU});
    end
    total++;
    if ({resultS, dzS} !== {eS, dS}) begin
      bad++; $display("[TB] FAIL %s signed-en result: got %h dz=%b, want %h dz=%b", tag,
                      resultS, dzS, eS, dS);
    end
    total++;
    if ({resultU, dzU} !== {eU, dU}) begin
      bad++; $display("[TB] FAIL %s unsigned-only result: got %h dz=%b, want %h dz=%b", tag,
                      resultU, dzU, eU, dU);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; op = 2'b00; sgn = 1'b0; a = 16'd5; b = 16'd7;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busyS, doneS, resultS, dzS} !== 19'd0) begin
      bad++; $display("[TB] FAIL reset signed-en: busy/done/result/dz=%b/%b/%h/%b, want 0/0/0000/0",
                      busyS, doneS, resultS, dzS);
    end
    total++;
    if ({busyU, doneU, resultU, dzU} !== 19'd0) begin
      bad++; $display("[TB] FAIL reset unsigned-only: busy/done/result/dz=%b/%b/%h/%b, want 0/0/0000/0",
                      busyU, doneU, resultU, dzU);
    end
    start = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    doOp(2'b00, 1'b0, 16'd300, 16'd200, "mul_u");
    doOp(2'b01, 1'b0, 16'd300, 16'd200, "mulh_u");
    doOp(2'b00, 1'b1, 16'hFFFD, 16'd7, "mul_s");
    doOp(2'b01, 1'b1, 16'hFFFD, 16'd7, "mulh_s");
    doOp(2'b01, 1'b1, 16'h8000, 16'h8000, "mulh_minmin");
  endtask

  task automatic test_div();
    doOp(2'b10, 1'b1, 16'hFFF9, 16'd2, "div_s");
    doOp(2'b11, 1'b1, 16'hFFF9, 16'd2, "rem_s");
    doOp(2'b10, 1'b0, 16'hFFF9, 16'd2, "div_u");
    doOp(2'b11, 1'b0, 16'hFFF9, 16'd2, "rem_u");
    doOp(2'b10, 1'b0, 16'h1234, 16'h0000, "div_zero");
    doOp(2'b11, 1'b1, 16'h1234, 16'h0000, "rem_zero");
    doOp(2'b00, 1'b0, 16'h0003, 16'h0005, "mul_clear_dz");
    doOp(2'b10, 1'b1, 16'h8000, 16'hFFFF, "div_ovf");
    doOp(2'b11, 1'b1, 16'h8000, 16'hFFFF, "rem_ovf");
  endtask

  // Result and div_zero must hold while idle, with inputs wiggling.
  task automatic test_hold();
    logic [15:0] keep;
    bit          changed;
    doOp(2'b10, 1'b0, 16'hABCD, 16'h0000, "hold_op");
    keep = resultS;
    changed = 1'b0;
    repeat (6) begin
      a = 16'($urandom); b = 16'($urandom); op = 2'($urandom);
      @(posedge clk); #1;
      if (resultS !== 16'hFFFF || dzS !== 1'b1 || doneS !== 1'b0 || busyS !== 1'b0) changed = 1'b1;
    end
    total++;
    if (changed !== 1'b0) begin
      bad++; $display("[TB] FAIL hold: result=%h dz=%b (first %h), want FFFF dz=1 idle", resultS, dzS, keep);
    end
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [15:0] x, y;
    for (int i = 0; i < 30; i++) begin
      o = 2'($urandom);
      x = 16'($urandom);
      y = 16'($urandom);
      if ($urandom_range(0, 7) == 0) y = 16'h0000;
      if ($urandom_range(0, 7) == 0) begin x = 16'h8000; y = 16'hFFFF; end
      if ($urandom_range(0, 3) == 0) y = 16'($urandom_range(1, 9));
      doOp(o, 1'($urandom), x, y, $sformatf("random%0d", i));
    end
  endtask

  task automatic test_back_to_back();
    doOp(2'b00, 1'b1, 16'h1234, 16'hFF00, "b2b_first");
    doOp(2'b11, 1'b1, 16'h8765, 16'h0011, "b2b_second");
    @(posedge clk); #1;
    total++;
    if (doneS !== 1'b0) begin
      bad++; $display("[TB] FAIL b2b pulse: done=%b one cycle later, want 0", doneS);
    end
  endtask

  task automatic test_ignore_start();
    logic [15:0] e, got;
    logic        dz;
    int          dones;
    e = refModel(2'b00, 1'b1, 16'h0123, 16'hFFF0, dz);
    op = 2'b00; sgn = 1'b1; a = 16'h0123; b = 16'hFFF0; start = 1'b1;
    @(posedge clk); #1;
    dones = 0;
    got = '0;
    for (int c = 0; c < 45; c++) begin
      if (doneS) begin dones++; got = resultS; end
      if (busyS) begin
        start = 1'($urandom); op = 2'($urandom); a = 16'($urandom); b = 16'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    total++;
    if (dones !== 1) begin
      bad++; $display("[TB] FAIL ignore_start count: got %0d dones, want 1", dones);
    end
    total++;
    if (got !== e) begin
      bad++; $display("[TB] FAIL ignore_start result: got %h, want %h", got, e);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    doOp(2'b00, 1'b0, 16'd300, 16'd200, "pre_abort");
    op = 2'b10; sgn = 1'b0; a = 16'h4444; b = 16'h0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if ({busyS, doneS, resultS, dzS} !== 19'd0) begin
      bad++; $display("[TB] FAIL abort state: busy/done/result/dz=%b/%b/%h/%b, want 0/0/0000/0",
                      busyS, doneS, resultS, dzS);
    end
    dones = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (doneS || doneU) dones++;
    end
    total++;
    if (dones !== 0) begin
      bad++; $display("[TB] FAIL abort no-done: got %0d dones, want 0", dones);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; start = 1'b0; op = '0; sgn = 1'b0; a = '0; b = '0;
    test_reset();
    test_mul();
    test_div();
    test_hold();
    test_back_to_back();
    test_ignore_start();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iter_muldiv.md
Name: iter_muldiv

Overview:
Parametrised multi-cycle multiply/divide unit. It replaces the single-cycle combinational MUL/DIV path in the core's ALU. Adds signed mode, high-half product, remainder, defined divide-by-zero behaviour, and a start/busy/done handshake. It sits beside the ALU; the control unit stalls pc while busy is high.

Parameters:
WIDTH, 16, operand/result width in bits (>= 4)
SIGNED_EN, 1, 1 = honour the sgn input; 0 = sgn is ignored and all operations are unsigned

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  request; sampled only while idle
op  in  2  00 MUL (low half), 01 MULH (high half), 10 DIV (quotient), 11 REM (remainder)
sgn  in  1  two's-complement operands when 1 (and SIGNED_EN=1)
a  in  WIDTH  multiplicand / dividend
b  in  WIDTH  multiplier / divisor
busy  out  1  operation in progress
done  out  1  single-cycle pulse; result and div_zero valid
result  out  WIDTH  held until the next done
div_zero  out  1  DIV/REM with b==0; held with result

Behaviour:
- Reset: reset rst, synchronous, active-high; clock clk. On reset: state=IDLE, busy=0, done=0, result=0, div_zero=0, iteration counter=0.
- Reset mid-operation aborts the operation. No done pulse is produced. Outputs take reset values at the next edge.
- States: IDLE -> PREP -> RUN -> FIX -> IDLE.
  - IDLE: start=1 latches a, b, op and effective sign (sgn & SIGNED_EN).
  - PREP (1 cycle): form operand magnitudes; record result signs; detect b==0 and signed overflow.
  - RUN (exactly WIDTH cycles): one shift-add (MUL) or restoring shift-subtract (DIV/REM) step per cycle. Counter runs 0..WIDTH-1.
  - FIX (1 cycle): apply sign correction and special cases; register result; raise done; return to IDLE.
- Latency is fixed at WIDTH+2 cycles for every operation, including special cases. If start is accepted at edge N:
  - busy is high for cycles N+1 .. N+WIDTH+1.
  - done is high in cycle N+WIDTH+2, and busy is low in that cycle.
- start asserted while busy=1 is ignored, with no queueing.
- start asserted in the done cycle is accepted, giving back-to-back operation.
- Operands are captured at acceptance. Changes on a/b/op/sgn during busy have no effect.
- MUL returns bits [WIDTH-1:0] of the 2*WIDTH-bit product. MULH returns bits [2*WIDTH-1:WIDTH]. Signed product = sign(a) xor sign(b) applied to the full 2*WIDTH magnitude.
- DIV truncates toward zero. REM takes the sign of the dividend. Invariant: a == q*b + r.
- Divide by zero: quotient = all ones, remainder = a, div_zero=1.
- Signed overflow (a = most negative value, b = -1, signed DIV/REM): quotient = a, remainder = 0, div_zero=0.
- div_zero is 0 for MUL/MULH.
- result and div_zero change only in the done cycle.

Decomposition:
- Shared package muldiv_pkg:
  - op encodings: OP_MUL, OP_MULH, OP_DIV, OP_REM.
  - state enum: IDLE, PREP, RUN, FIX.
  - helper function for two's-complement magnitude.
- Control.opMul/opDiv decoding maps onto these op codes in the core.
- One natural sub-module: muldiv_step. It is a combinational single iteration computing the next {acc, shift register} for either mode. It is instantiated once, and the FSM and counter stay in iter_muldiv.

Test Plan:
All cases use WIDTH=16.
1. MUL, sgn=0, a=300, b=200, start at edge N -> done at N+18, result=0xEA60, busy high N+1..N+17. Repeat with MULH -> result=0x0000.
2. MUL and MULH, sgn=1, a=0xFFFD (-3), b=7 -> MUL 0xFFEB, MULH 0xFFFF. Repeat with SIGNED_EN=0 -> MUL 0xFFEB, MULH 0x0006.
3. DIV and REM, sgn=1, a=0xFFF9 (-7), b=2 -> DIV 0xFFFD, REM 0xFFFF. Repeat with sgn=0 -> DIV 0x7FFC, REM 0x0001.
4. DIV, a=0x1234, b=0 -> result=0xFFFF, div_zero=1. REM with the same operands -> 0x1234, div_zero=1. A following MUL clears div_zero at its done.
5. Signed DIV, a=0x8000, b=0xFFFF -> 0x8000, div_zero=0. REM with the same operands -> 0x0000.
6. Handshake:
   - start pulses during busy are ignored, giving exactly one done.
   - start in the done cycle -> second done exactly 18 cycles later.
   - rst at busy cycle 5 -> busy=0 and result=0 next cycle; no done for 20 cycles.
